// File: rtl/bsg_reduce_segmented_seq_pkg.sv
// Shared types for the segmented sequential reducer: op and FSM state enums and
// the per-op accumulator seed.
package bsg_reduce_segmented_seq_pkg;

    typedef enum logic [1:0] {
        e_red_and  = 2'b00,
        e_red_or   = 2'b01,
        e_red_xor  = 2'b10,
        e_red_rsvd = 2'b11
    } red_op_e;

    typedef enum logic [1:0] {
        e_idle = 2'b00,
        e_busy = 2'b01,
        e_done = 2'b10
    } red_state_e;

    // Identity element of the op; reserved reduces as AND.
    function automatic logic acc_init(red_op_e op);
        return (op == e_red_and) || (op == e_red_rsvd);
    endfunction

endpackage

// File: rtl/bsg_reduce_segmented_beat.sv
// One beat of the segmented reduce: folds beat_width_p bits of every segment into
// that segment's accumulator. Purely combinational.
module bsg_reduce_segmented_beat
    import bsg_reduce_segmented_seq_pkg::*;
#(
    parameter int unsigned segments_p   = 5,
    parameter int unsigned beat_width_p = 8
) (
    input  logic [segments_p*beat_width_p-1:0] beat_i,
    input  red_op_e                            op_i,
    input  logic [segments_p-1:0]              acc_i,
    output logic [segments_p-1:0]              acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int s = 0; s < int'(segments_p); s++) begin
            unique case (op_i)
                e_red_or:  acc_o[s] = acc_i[s] | (|beat_i[s*beat_width_p +: beat_width_p]);
                e_red_xor: acc_o[s] = acc_i[s] ^ (^beat_i[s*beat_width_p +: beat_width_p]);
                default:   acc_o[s] = acc_i[s] & (&beat_i[s*beat_width_p +: beat_width_p]);
            endcase
        end
    end

endmodule

// File: rtl/bsg_reduce_segmented_seq.sv
// Multi-cycle segmented AND/OR/XOR reducer, beat_width_p bits per segment per cycle.
// Define BSG_REDUCE_SEGMENTED_SEQ_EARLY_TERM_EN to stop once the result is saturated.
module bsg_reduce_segmented_seq
    import bsg_reduce_segmented_seq_pkg::*;
#(
    parameter int unsigned segments_p      = 5,
    parameter int unsigned segment_width_p = 32,
    parameter int unsigned beat_width_p    = 8,
    localparam int unsigned beats_lp       = segment_width_p / beat_width_p,
    localparam int unsigned cnt_width_lp   = $clog2(beats_lp + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  v_i,
    output logic                                  ready_o,
    input  logic [segments_p*segment_width_p-1:0] data_i,
    input  logic [1:0]                            op_i,
    output logic                                  v_o,
    output logic [segments_p-1:0]                 data_o,
    output logic [cnt_width_lp-1:0]               beats_o,
    input  logic                                  yumi_i
);

    localparam int unsigned total_width_lp = segments_p * segment_width_p;

    red_state_e                     state_q;
    red_op_e                        op_q;
    logic [total_width_lp-1:0]      shift_q;
    logic [total_width_lp-1:0]      shift_d;
    logic [segments_p*beat_width_p-1:0] beat_slice;
    logic [segments_p-1:0]          acc_q;
    logic [segments_p-1:0]          acc_d;
    logic [cnt_width_lp-1:0]        cnt_q;
    logic                           ready_q;
    logic                           v_q;
    logic                           last_beat;
    logic                           early_stop;
    red_op_e                        op_in;

    assign op_in = red_op_e'(op_i);

    // Low beat of each segment feeds the datapath; segments shift in lockstep.
    always_comb begin
        beat_slice = '0;
        shift_d    = '0;
        for (int s = 0; s < int'(segments_p); s++) begin
            beat_slice[s*beat_width_p +: beat_width_p] =
                shift_q[s*segment_width_p +: beat_width_p];
            shift_d[s*segment_width_p +: segment_width_p] =
                shift_q[s*segment_width_p +: segment_width_p] >> beat_width_p;
        end
    end

    bsg_reduce_segmented_beat #(
        .segments_p   (segments_p),
        .beat_width_p (beat_width_p)
    ) u_beat (
        .beat_i (beat_slice),
        .op_i   (op_q),
        .acc_i  (acc_q),
        .acc_o  (acc_d)
    );

    assign last_beat = (cnt_q == cnt_width_lp'(beats_lp - 1));

`ifdef BSG_REDUCE_SEGMENTED_SEQ_EARLY_TERM_EN
    assign early_stop = ((op_q == e_red_and || op_q == e_red_rsvd) && (acc_d == '0))
                     || ((op_q == e_red_or) && (acc_d == '1));
`else
    assign early_stop = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            op_q    <= e_red_and;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            v_q     <= 1'b0;
        end else begin
            unique case (state_q)
                e_idle: begin
                    if (v_i) begin
                        shift_q <= data_i;
                        op_q    <= op_in;
                        acc_q   <= {segments_p{acc_init(op_in)}};
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= e_busy;
                    end
                end
                e_busy: begin
                    acc_q   <= acc_d;
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + cnt_width_lp'(1);
                    if (last_beat || early_stop) begin
                        v_q     <= 1'b1;
                        state_q <= e_done;
                    end
                end
                e_done: begin
                    if (yumi_i) begin
                        v_q     <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= e_idle;
                    end
                end
                default: begin
                    v_q     <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= e_idle;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign v_o     = v_q;
    assign data_o  = acc_q;
    assign beats_o = cnt_q;

endmodule
